// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios input PIO: register offsets, edge-mode codes
// and the per-bit edge qualifier.
package nios_pio_pkg;

  localparam int unsigned PIO_BUS_W  = 32;
  localparam int unsigned PIO_ADDR_W = 2;

  typedef enum logic [PIO_ADDR_W-1:0] {
    PIO_REG_DATA    = 2'd0,
    PIO_REG_RAW     = 2'd1,
    PIO_REG_IRQMASK = 2'd2,
    PIO_REG_EDGECAP = 2'd3
  } pio_reg_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // True when the transition prev -> cur is one the selected mode captures.
  function automatic logic edge_hit(input int unsigned mode, input logic cur, input logic prev);
    logic hit;
    hit = cur & ~prev;
    if (mode == EDGE_FALL) begin
      hit = ~cur & prev;
    end else if (mode == EDGE_ANY) begin
      hit = cur ^ prev;
    end
    return hit;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit debouncer: the stable value follows the synchronised input only
// after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Any return to the stable value restarts the qualification window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= i_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, optional debounce, edge capture and IRQ.
// Build option: define PIO_DEBOUNCE_EN to instantiate the per-bit debouncers.
module nios_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic [PIO_ADDR_W-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [PIO_BUS_W-1:0]  writedata,
  output logic [PIO_BUS_W-1:0]  readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     r_stable_d;
  logic [WIDTH-1:0]     r_irqmask;
  logic [WIDTH-1:0]     r_edgecap;
  logic [WIDTH-1:0]     w_raw;
  logic [WIDTH-1:0]     w_stable;
  logic [WIDTH-1:0]     w_edge;
  logic [WIDTH-1:0]     w_clr;
  logic                 w_rd;
  logic                 w_wr_mask;
  logic                 w_wr_cap;
  logic [PIO_BUS_W-1:0] w_rdata;

  // Out-of-range configurations are flagged by this marker scope; no hardware.
  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 2 || EDGE_MODE > EDGE_ANY) begin : g_param_range_violation
  end

  if (WIDTH < PIO_BUS_W) begin : g_wd_upper
    logic w_unused_wd;
    assign w_unused_wd = ^writedata[PIO_BUS_W-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_raw = r_sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  for (genvar b = 0; b < WIDTH; b++) begin : g_debounce
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .i_sync   (w_raw[b]),
      .o_stable (w_stable[b])
    );
  end
`else
  assign w_stable = w_raw;
`endif

  always_comb begin
    w_edge = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_edge[b] = edge_hit(EDGE_MODE, w_stable[b], r_stable_d[b]);
    end
  end

  assign w_rd      = chipselect & read;
  assign w_wr_mask = chipselect & write & (address == PIO_REG_IRQMASK);
  assign w_wr_cap  = chipselect & write & (address == PIO_REG_EDGECAP);
  assign w_clr     = w_wr_cap ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed in after the clear so a coincident set survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d <= '0;
      r_irqmask  <= '0;
      r_edgecap  <= '0;
    end else begin
      r_stable_d <= w_stable;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr_mask) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      PIO_REG_DATA:    w_rdata = PIO_BUS_W'(w_stable);
      PIO_REG_RAW:     w_rdata = PIO_BUS_W'(w_raw);
      PIO_REG_IRQMASK: w_rdata = PIO_BUS_W'(r_irqmask);
      PIO_REG_EDGECAP: w_rdata = PIO_BUS_W'(r_edgecap);
      default:         w_rdata = '0;
    endcase
  end

  // readdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (w_rd) begin
      readdata <= w_rdata;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Directed bench for nios_pio_in_edge; expectations adapt to PIO_DEBOUNCE_EN.
module tb_nios_pio_in_edge;

  localparam int unsigned W   = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned DBC = 4;
`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned DB = DBC;
  localparam int unsigned EM = 0;
`else
  localparam int unsigned DB = 0;
  localparam int unsigned EM = 2;
`endif
  localparam int unsigned LAT = SS + DB;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_RAW  = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CAP  = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          chipselect;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_pio_in_edge #(
    .WIDTH           (W),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DBC),
    .EDGE_MODE       (EM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    tick(1);
    chipselect = 1'b0;
    read       = 1'b0;
    chk(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; address = '0; read = 1'b0;
    write = 1'b0; writedata = '0; in_port = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Build up state, then reset mid-run
    wr(A_MASK, 32'hF);
    in_port = 4'hF;
    tick(LAT + 3);
    chk("irq_before_reset", 32'(irq), 32'h1);
    reset   = 1'b1;
    in_port = 4'h0;
    tick(2);
    chk("irq_in_reset", 32'(irq), 32'h0);
    chk("readdata_in_reset", readdata, 32'h0);
    reset = 1'b0;
    rd(A_DATA, 32'h0, "rst_data");
    rd(A_RAW,  32'h0, "rst_raw");
    rd(A_MASK, 32'h0, "rst_mask");
    rd(A_CAP,  32'h0, "rst_cap");
    chk("rst_irq", 32'(irq), 32'h0);

    // Three-cycle pulse on bit 0
    in_port = 4'h1;
    tick(2);
    rd(A_RAW, 32'h1, "glitch_raw");
    in_port = 4'h0;
    rd(A_DATA, (DB == 0) ? 32'h1 : 32'h0, "glitch_data_early");
    tick(10);
    rd(A_DATA, 32'h0, "glitch_data_late");
    rd(A_CAP, (DB == 0) ? 32'h1 : 32'h0, "glitch_cap");
    wr(A_CAP, 32'hF);
    rd(A_CAP, 32'h0, "glitch_cap_clr");

    // Held input: exact RAW->DATA->EDGECAP/irq latency
    wr(A_MASK, 32'h1);
    rd(A_MASK, 32'h1, "mask_rb");
    in_port = 4'h1;
    tick(LAT - 1);
    rd(A_DATA, 32'h0, "lat_data_before");
    chk("lat_irq_before", 32'(irq), 32'h0);
    rd(A_DATA, 32'h1, "lat_data_at");
    chk("lat_irq_at", 32'(irq), 32'h1);
    rd(A_CAP, 32'h1, "lat_cap");

    // W1C drops irq on the cycle after the write edge
    wr(A_CAP, 32'h1);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd(A_CAP, 32'h0, "w1c_cap");

    // Clear and set of bit 2 on the same edge
    in_port = 4'h5;
    tick(LAT);
    wr(A_CAP, 32'h4);
    rd(A_CAP, 32'h4, "collide_cap");
    chk("collide_irq", 32'(irq), 32'h0);
    wr(A_CAP, 32'h4);
    rd(A_CAP, 32'h0, "collide_clr");

    // Mask gating with edges on all bits
    wr(A_MASK, 32'h0);
    in_port = 4'h0;
    tick(LAT + 3);
    wr(A_CAP, 32'hF);
    in_port = 4'hF;
    tick(LAT + 3);
    rd(A_CAP, 32'hF, "gate_cap");
    chk("gate_irq_off", 32'(irq), 32'h0);
    wr(A_MASK, 32'h8);
    chk("gate_irq_on", 32'(irq), 32'h1);
    rd(A_MASK, 32'h8, "gate_mask_rb");
    wr(A_MASK, 32'hFFFF_FFF3);
    rd(A_MASK, 32'h3, "mask_upper_zero");

    // Read-only offsets ignore writes
    wr(A_DATA, 32'h0);
    wr(A_RAW, 32'h0);
    rd(A_DATA, 32'hF, "ro_data");
    rd(A_RAW, 32'hF, "ro_raw");

    // Falling edge on bit 1 only captured in any-edge mode
    wr(A_CAP, 32'hF);
    rd(A_CAP, 32'h0, "fall_clr");
    in_port = 4'hD;
    tick(LAT + 3);
    rd(A_CAP, (EM == 2) ? 32'h2 : 32'h0, "fall_cap");
    rd(A_DATA, 32'hD, "fall_data");

    // readdata holds without a read strobe
    in_port = 4'hF;
    tick(LAT + 3);
    chk("rd_hold", readdata, 32'hD);
    rd(A_DATA, 32'hF, "rise_data");
    rd(A_CAP, 32'h2, "rise_cap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_pio_in_edge.md
# nios_pio_in_edge

Parametrised Avalon-MM input PIO slave for the Nios platforms. It is the successor to the fixed 10-bit switch port. Each input bit passes through a configurable synchroniser, an optional per-bit debouncer and an edge detector, which feeds a write-1-to-clear edge-capture register. A maskable level interrupt is raised to the Nios IRQ controller. The block sits between board-level switches/buttons and the Qsys interconnect.

## Interface
Parameters:
- WIDTH, 10: number of input bits (1..32).
- SYNC_STAGES, 2: synchroniser flops per bit (2..4).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a debounced bit changes (≥2). Ignored without PIO_DEBOUNCE_EN.
- EDGE_MODE, 0: edge that sets capture. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- address  in  2  word address.
- read  in  1  read strobe; a read is `chipselect & read`.
- write  in  1  write strobe; a write is `chipselect & write`.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt.

## Operation
Register map (word offsets). Unused upper bits read 0:
- 0 DATA (RO): debounced input value.
- 1 RAW (RO): synchroniser output, before debounce.
- 2 IRQMASK (RW): per-bit interrupt enable. Writes take `writedata[WIDTH-1:0]`.
- 3 EDGECAP (RW1C): per-bit sticky edge flags. Writing a 1 clears the bit; writing a 0 has no effect.

Behaviour:
- Writes to offsets 0 and 1 are ignored.
- Debounce, per bit:
  - Keep a stable value and a counter of `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - If the synced bit equals stable, clear the counter.
  - Otherwise increment the counter. At the edge where the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, stable takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches DATA.
- Edge detect compares stable against a one-cycle-delayed copy (stable_d). The edge selected by EDGE_MODE sets the EDGECAP bit.
- If an EDGECAP set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq = OR over (EDGECAP & IRQMASK). It is combinational from flops, so it has no added register.
- On reset:
  - readdata = 0, irq = 0.
  - IRQMASK = 0, EDGECAP = 0.
  - Sync chain, stable, stable_d and counters = 0.
- Reset mid-debounce discards the partial count. After reset, an input held at 1 produces a rising edge once it has been debounced.

## Timing
- Read latency is 1: readdata updates at the edge after the read strobe and holds its value until the next read. No wait states.
- Writes take effect at the strobe edge and are visible to a read issued on the next cycle.
- in_port to RAW: SYNC_STAGES edges.
- RAW to DATA: DEBOUNCE_CYCLES edges when debounce is enabled, 0 when it is compiled out.
- DATA to EDGECAP set: 1 edge. irq asserts in the same cycle as the EDGECAP set when the mask bit is 1.
- EDGECAP clear to irq deassert: the cycle after the write edge, provided no other masked bit is set.

## Configuration
- PIO_DEBOUNCE_EN defined: debounce cells are instantiated and DEBOUNCE_CYCLES applies.
- PIO_DEBOUNCE_EN undefined: stable = synchroniser output directly, no counters are generated, and DATA equals RAW.

## Structure
- Shared package nios_pio_pkg:
  - Register offset constants: PIO_REG_DATA = 0, PIO_REG_RAW = 1, PIO_REG_IRQMASK = 2, PIO_REG_EDGECAP = 3.
  - EDGE_MODE constants: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One sub-module, pio_debounce_bit, holding the per-bit counter and stable value. It is instantiated WIDTH times under the generate/macro guard.

## Test plan
Bench parameters: WIDTH = 4, SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4, macro defined unless stated.
- Reset values: assert reset mid-run, read all four offsets -> every read returns 0x0 and irq = 0.
- Debounce filter:
  - in_port[0] pulse of 3 cycles -> RAW shows it, DATA stays 0x0.
  - in_port[0] held high -> DATA = 0x1 exactly 2+4 edges after the input change.
- Edge capture and IRQ, EDGE_MODE = 0:
  - Write IRQMASK = 0x1, raise in_port[0] -> EDGECAP = 0x1 and irq = 1 one edge after DATA.
  - Write EDGECAP = 0x1 -> irq = 0 on the next cycle.
- Set/clear collision: schedule the W1C of bit 2 on the same edge as a new rising edge on bit 2 -> EDGECAP bit 2 remains 1.
- Mask gating: IRQMASK = 0x0 with edges on bits 0-3 -> EDGECAP = 0xF and irq = 0. Then write IRQMASK = 0x8 -> irq = 1.
- Macro off, EDGE_MODE = 2: toggle in_port[1] high then low -> DATA follows RAW with zero extra delay, and EDGECAP bit 1 is set by each transition.
